// File: rtl/acc_cpu_pkg.sv
// Shared encodings for acc_cpu_core: opcodes, FSM states, ALU ops, skip conditions, IR field layout.
// Optional feature macro used by the core: ACC_CPU_INDIRECT_EN.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_HALT  = 4'h1,
        OP_LOAD  = 4'h2,
        OP_STORE = 4'h3,
        OP_CLEAR = 4'h4,
        OP_SKIP  = 4'h5,
        OP_JUMP  = 4'h6,
        OP_SUB   = 4'h7,
        OP_AND   = 4'h8,
        OP_OR    = 4'h9,
        OP_NOT   = 4'hA
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_MRD,
        S_MWAIT,
        S_EXEC,
        S_STORE,
        S_HALT,
        S_IRD,
        S_IWAIT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOT,
        ALU_PASS
    } alu_op_e;

    localparam logic [1:0] SKIP_NEG  = 2'b00;
    localparam logic [1:0] SKIP_ZERO = 2'b01;
    localparam logic [1:0] SKIP_POS  = 2'b10;

    localparam int unsigned IND_BIT  = 31;
    localparam int unsigned OPC_MSB  = 30;
    localparam int unsigned OPC_LSB  = 27;
    localparam int unsigned OPR_MSB  = 26;
    localparam int unsigned SKIP_MSB = 11;
    localparam int unsigned SKIP_LSB = 10;

    // Opcodes that fetch an operand from memory before updating AC.
    function automatic logic is_mem_read(input logic [3:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) ||
               (opc == OP_OR)  || (opc == OP_LOAD);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: a_i is AC, b_i is the memory operand; results wrap modulo 2^DATA_WIDTH.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  alu_op_e               op_i,
    output logic [DATA_WIDTH-1:0] y_o
);

    always_comb begin
        y_o = b_i;
        case (op_i)
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_NOT:  y_o = ~a_i;
            ALU_PASS: y_o = b_i;
            default:  y_o = b_i;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU driving a 1-cycle-latency synchronous RAM.
// Define ACC_CPU_INDIRECT_EN to enable IR[31] indirect addressing on memory ops.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned RESET_PC   = 'h100,
    parameter int unsigned PC_STEP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC  = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    state_e                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [ADDR_WIDTH-1:0] pc_q,    pc_d;
    logic [DATA_WIDTH-1:0] ac_q,    ac_d;
    logic [DATA_WIDTH-1:0] ir_q,    ir_d;
    logic [DATA_WIDTH-1:0] mbr_q,   mbr_d;
    logic [ADDR_WIDTH-1:0] ea_q,    ea_d;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic                  indirect;
    logic                  skip_taken;
    alu_op_e               alu_op;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  unused_bits;

    assign opcode = ir_q[OPC_MSB:OPC_LSB];

    if (ADDR_WIDTH <= OPR_MSB + 1) begin : g_opr_trunc
        assign operand = ir_q[ADDR_WIDTH-1:0];
    end else begin : g_opr_zext
        assign operand = {{(ADDR_WIDTH-OPR_MSB-1){1'b0}}, ir_q[OPR_MSB:0]};
    end

`ifdef ACC_CPU_INDIRECT_EN
    assign indirect = ir_q[IND_BIT];
`else
    assign indirect = 1'b0;
`endif

    assign unused_bits = ^{ir_q, mem_rdata};

    always_comb begin
        skip_taken = 1'b0;
        case (ir_q[SKIP_MSB:SKIP_LSB])
            SKIP_NEG:  skip_taken = ac_q[DATA_WIDTH-1];
            SKIP_ZERO: skip_taken = (ac_q == '0);
            SKIP_POS:  skip_taken = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
            default:   skip_taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = ALU_PASS;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_NOT:  alu_op = ALU_NOT;
            default: alu_op = ALU_PASS;
        endcase
    end

    acc_cpu_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a_i (ac_q),
        .b_i (mbr_q),
        .op_i(alu_op),
        .y_o (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            armed_q <= 1'b0;
            pc_q    <= PC_INIT;
            ac_q    <= '0;
            ir_q    <= '0;
            mbr_q   <= '0;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            mbr_q   <= mbr_d;
            ea_q    <= ea_d;
        end
    end

    // armed_q holds FETCH quiet for the first cycle out of reset, so a write
    // issued in the cycle rst is sampled is never followed by another access.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        mbr_d   = mbr_q;
        ea_d    = ea_q;
        case (state_q)
            S_FETCH: begin
                if (!armed_q) armed_d = 1'b1;
                else          state_d = S_FWAIT;
            end
            S_FWAIT: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + PC_INC;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ea_d    = operand;
                state_d = S_FETCH;
                if (is_mem_read(opcode)) begin
                    state_d = indirect ? S_IRD : S_MRD;
                end else begin
                    case (opcode)
                        OP_STORE: state_d = indirect ? S_IRD : S_STORE;
                        OP_HALT:  state_d = S_HALT;
                        OP_CLEAR: ac_d = '0;
                        OP_NOT:   ac_d = alu_y;
                        OP_SKIP:  if (skip_taken) pc_d = pc_q + PC_INC;
                        OP_JUMP:  pc_d = operand;
                        default:  ;
                    endcase
                end
            end
            S_IRD:   state_d = S_IWAIT;
            S_IWAIT: begin
                ea_d    = mem_rdata[ADDR_WIDTH-1:0];
                state_d = (opcode == OP_STORE) ? S_STORE : S_MRD;
            end
            S_MRD:   state_d = S_MWAIT;
            S_MWAIT: begin
                mbr_d   = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ac_d    = alu_y;
                state_d = S_FETCH;
            end
            S_STORE: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (armed_q) begin
                    mem_addr = pc_q;
                    mem_cs   = 1'b1;
                    mem_oe   = 1'b1;
                end
            end
            S_MRD, S_IRD: begin
                mem_addr = ea_q;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_STORE: begin
                mem_addr  = ea_q;
                mem_wdata = ac_q;
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT);
    assign pc_out = pc_q;
    assign ac_out = ac_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: behavioural sync RAM, store-write scoreboard, fetch-trace latency checks.
module tb_acc_cpu_core;

    localparam int DW = 32;
    localparam int AW = 14;

    localparam logic [3:0] ADD = 4'h0, HLT = 4'h1, LDA = 4'h2, STA = 4'h3, CLR = 4'h4,
                           SKP = 4'h5, JMP = 4'h6, SUB = 4'h7, ANDI = 4'h8, ORI = 4'h9,
                           NOTI = 4'hA, NOP = 4'hB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_cs, mem_we, mem_oe, halted;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ac_out;

    logic          tb_wr = 1'b0;
    logic [AW-1:0] tb_a  = '0;
    logic [DW-1:0] tb_d  = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [45:0]   wr_q[$];
    logic [45:0]   exp_q[$];
    logic [AW-1:0] fa_q[$];
    int            fc_q[$];
    int            cyc = 0;
    int            we_oe_bad = 0;
    int            hlt_cs_bad = 0;
    int            wr_b, fa_b, nexp;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    acc_cpu_core #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  ('h100),
        .PC_STEP   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_oe   (mem_oe),
        .halted   (halted),
        .pc_out   (pc_out),
        .ac_out   (ac_out)
    );

    // Single-port sync RAM plus bus monitors; the bench preloads through tb_wr while the core is in reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tb_wr) mem[tb_a] <= tb_d;
        else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_cs && mem_oe && !mem_we) mem_rdata <= mem[mem_addr];
        if (mem_cs && mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (mem_cs && mem_oe && !mem_we && mem_addr < 14'h130) begin
            fa_q.push_back(mem_addr);
            fc_q.push_back(cyc);
        end
        if (mem_we && mem_oe) we_oe_bad <= we_oe_bad + 1;
        if (halted && mem_cs) hlt_cs_bad <= hlt_cs_bad + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input int unsigned opr);
        return {1'b0, op, opr[26:0]};
    endfunction

    function automatic int fcyc(input logic [AW-1:0] a);
        for (int i = fa_b; i < fa_q.size(); i++) if (fa_q[i] == a) return fc_q[i];
        return -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_wr = 1'b1; tb_a = a; tb_d = d;
        tick();
        tb_wr = 1'b0;
    endtask

    task automatic prep();
        rst = 1'b1;
        for (int a = 'h100; a < 'h150; a++) poke(AW'(a), '0);
    endtask

    task automatic start();
        wr_b = wr_q.size();
        fa_b = fa_q.size();
        rst  = 1'b0;
        tick();
    endtask

    task automatic run_halt(input int maxc, output int n);
        n = 0;
        while (!halted && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++; if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {mem_cs, mem_we, mem_oe}); end
        n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_chk++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_chk++; if (pc_out !== 14'h100) begin n_fail++; $display("FAIL rst_pc: got %h want 100", pc_out); end
        n_chk++; if (ac_out !== '0) begin n_fail++; $display("FAIL rst_ac: got %h want 0", ac_out); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
        rst = 1'b0;
        n_chk++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_release_quiet: cs got %b want 0", mem_cs); end
        tick();
        n_chk++; if (mem_addr !== 14'h100) begin n_fail++; $display("FAIL first_fetch_addr: got %h want 100", mem_addr); end
        n_chk++; if ({mem_cs, mem_we, mem_oe} !== 3'b101) begin n_fail++; $display("FAIL first_fetch_strobes: got %b want 101", {mem_cs, mem_we, mem_oe}); end
    endtask

    task automatic test_basic();
        int n;
        prep();
        poke('h100, ins(LDA, 'h11E)); poke('h102, ins(ADD, 'h120));
        poke('h104, ins(STA, 'h11C)); poke('h106, ins(HLT, 0));
        poke('h11E, 3); poke('h120, 5);
        start();
        exp_q.push_back({14'h11C, 32'd8});
        run_halt(200, n);
        n_chk++; if (n >= 200) begin n_fail++; $display("FAIL basic_timeout: cycles %0d want <200", n); end
        n_chk++; if (pc_out !== 14'h108) begin n_fail++; $display("FAIL basic_pc: got %h want 108", pc_out); end
        n_chk++; if (ac_out !== 32'd8) begin n_fail++; $display("FAIL basic_ac: got %h want 8", ac_out); end
        n_chk++; if (mem['h11C] !== 32'd8) begin n_fail++; $display("FAIL basic_mem11C: got %h want 8", mem['h11C]); end
        n_chk++; if (fcyc('h102) - fcyc('h100) !== 6) begin n_fail++; $display("FAIL lat_load: got %0d want 6", fcyc('h102) - fcyc('h100)); end
        n_chk++; if (fcyc('h104) - fcyc('h102) !== 6) begin n_fail++; $display("FAIL lat_add: got %0d want 6", fcyc('h104) - fcyc('h102)); end
        n_chk++; if (fcyc('h106) - fcyc('h104) !== 4) begin n_fail++; $display("FAIL lat_store: got %0d want 4", fcyc('h106) - fcyc('h104)); end
        nexp = exp_q.size();
        for (int i = 0; i < nexp; i++) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_b + i >= wr_q.size()) begin n_fail++; $display("FAIL basic_wr%0d: missing, want %h", i, e); end
            else if (wr_q[wr_b + i] !== e) begin n_fail++; $display("FAIL basic_wr%0d: got %h want %h", i, wr_q[wr_b + i], e); end
        end
        n_chk++; if (wr_q.size() - wr_b !== nexp) begin n_fail++; $display("FAIL basic_wr_count: got %0d want %0d", wr_q.size() - wr_b, nexp); end
    endtask

    task automatic test_fib();
        int n;
        logic [31:0] a, b, nw, k;
        prep();
        poke('h100, ins(LDA, 'h130)); poke('h102, ins(ADD, 'h131)); poke('h104, ins(STA, 'h132));
        poke('h106, ins(LDA, 'h131)); poke('h108, ins(STA, 'h130)); poke('h10A, ins(LDA, 'h132));
        poke('h10C, ins(STA, 'h131)); poke('h10E, ins(STA, 'h135)); poke('h110, ins(LDA, 'h133));
        poke('h112, ins(SUB, 'h134)); poke('h114, ins(STA, 'h133)); poke('h116, ins(SKP, 1 << 10));
        poke('h118, ins(JMP, 'h100)); poke('h11A, ins(HLT, 0));
        poke('h130, 0); poke('h131, 1); poke('h133, 9); poke('h134, 1);
        start();
        a = 0; b = 1; k = 9;
        do begin
            nw = a + b;
            exp_q.push_back({14'h132, nw});
            exp_q.push_back({14'h130, b});
            a = b; b = nw;
            exp_q.push_back({14'h131, nw});
            exp_q.push_back({14'h135, nw});
            k = k - 1;
            exp_q.push_back({14'h133, k});
        end while (k != 0);
        run_halt(2000, n);
        n_chk++; if (n >= 2000) begin n_fail++; $display("FAIL fib_timeout: cycles %0d want <2000", n); end
        n_chk++; if (mem['h135] !== 32'd55) begin n_fail++; $display("FAIL fib_last: got %0d want 55", mem['h135]); end
        n_chk++; if (pc_out !== 14'h11C) begin n_fail++; $display("FAIL fib_pc: got %h want 11C", pc_out); end
        nexp = exp_q.size();
        for (int i = 0; i < nexp; i++) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_b + i >= wr_q.size()) begin n_fail++; $display("FAIL fib_wr%0d: missing, want %h", i, e); end
            else if (wr_q[wr_b + i] !== e) begin n_fail++; $display("FAIL fib_wr%0d: got %h want %h", i, wr_q[wr_b + i], e); end
        end
        n_chk++; if (wr_q.size() - wr_b !== nexp) begin n_fail++; $display("FAIL fib_wr_count: got %0d want %0d", wr_q.size() - wr_b, nexp); end
    endtask

    task automatic test_skip();
        int n;
        logic [AW-1:0] want [6];
        want = '{14'h100, 14'h102, 14'h106, 14'h108, 14'h10A, 14'h10C};
        prep();
        poke('h100, ins(LDA, 'h130)); poke('h102, ins(SKP, 0 << 10)); poke('h104, ins(CLR, 0));
        poke('h106, ins(SKP, 2 << 10)); poke('h108, ins(SKP, 3 << 10)); poke('h10A, ins(STA, 'h131));
        poke('h10C, ins(HLT, 0));
        poke('h130, 32'hFFFF_FFFF);
        start();
        run_halt(200, n);
        n_chk++; if (n >= 200) begin n_fail++; $display("FAIL skip_timeout: cycles %0d want <200", n); end
        n_chk++; if (fa_q.size() - fa_b !== 6) begin n_fail++; $display("FAIL skip_fetch_count: got %0d want 6", fa_q.size() - fa_b); end
        for (int i = 0; i < 6 && fa_b + i < fa_q.size(); i++) begin
            n_chk++;
            if (fa_q[fa_b + i] !== want[i]) begin n_fail++; $display("FAIL skip_fetch%0d: got %h want %h", i, fa_q[fa_b + i], want[i]); end
        end
        n_chk++; if (mem['h131] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL skip_store: got %h want FFFFFFFF", mem['h131]); end
        n_chk++; if (pc_out !== 14'h10E) begin n_fail++; $display("FAIL skip_pc: got %h want 10E", pc_out); end
    endtask

    task automatic test_alu();
        int n;
        logic [31:0] va, vb, vc, d;
        va = 32'hF0F0_1234; vb = 32'h0FF0_5678; vc = 32'hFFFF_FFFF;
        prep();
        poke('h100, ins(LDA, 'h130)); poke('h102, ins(ANDI, 'h131)); poke('h104, ins(STA, 'h140));
        poke('h106, ins(LDA, 'h130)); poke('h108, ins(ORI, 'h131));  poke('h10A, ins(STA, 'h141));
        poke('h10C, ins(LDA, 'h131)); poke('h10E, ins(SUB, 'h130));  poke('h110, ins(STA, 'h142));
        poke('h112, ins(NOTI, 0));    poke('h114, ins(STA, 'h143));  poke('h116, ins(ADD, 'h132));
        poke('h118, ins(STA, 'h144)); poke('h11A, ins(CLR, 0));      poke('h11C, ins(NOP, 'h131));
        poke('h11E, ins(STA, 'h145)); poke('h120, ins(JMP, 'h127));  poke('h122, ins(HLT, 0));
        poke('h127, ins(HLT, 0));
        poke('h130, va); poke('h131, vb); poke('h132, vc);
        start();
        exp_q.push_back({14'h140, va & vb});
        exp_q.push_back({14'h141, va | vb});
        d = vb - va;
        exp_q.push_back({14'h142, d});
        d = ~d;
        exp_q.push_back({14'h143, d});
        d = d + vc;
        exp_q.push_back({14'h144, d});
        exp_q.push_back({14'h145, 32'h0});
        run_halt(400, n);
        n_chk++; if (n >= 400) begin n_fail++; $display("FAIL alu_timeout: cycles %0d want <400", n); end
        n_chk++; if (pc_out !== 14'h129) begin n_fail++; $display("FAIL odd_jump_pc: got %h want 129", pc_out); end
        nexp = exp_q.size();
        for (int i = 0; i < nexp; i++) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_b + i >= wr_q.size()) begin n_fail++; $display("FAIL alu_wr%0d: missing, want %h", i, e); end
            else if (wr_q[wr_b + i] !== e) begin n_fail++; $display("FAIL alu_wr%0d: got %h want %h", i, wr_q[wr_b + i], e); end
        end
        n_chk++; if (wr_q.size() - wr_b !== nexp) begin n_fail++; $display("FAIL alu_wr_count: got %0d want %0d", wr_q.size() - wr_b, nexp); end
    endtask

    task automatic test_rst_store();
        int n;
        prep();
        poke('h100, ins(LDA, 'h130)); poke('h102, ins(STA, 'h131)); poke('h104, ins(HLT, 0));
        poke('h130, 32'h5A5A_0001);
        start();
        exp_q.push_back({14'h131, 32'h5A5A_0001});
        exp_q.push_back({14'h131, 32'h5A5A_0001});
        n = 0;
        while (!mem_we && n < 50) begin tick(); n++; end
        n_chk++; if (n >= 50) begin n_fail++; $display("FAIL rs_wait_store: cycles %0d want <50", n); end
        rst = 1'b1;
        tick();
        n_chk++; if ({mem_addr, mem_wdata, mem_cs, mem_we, mem_oe} !== '0) begin n_fail++; $display("FAIL rs_bus_reset: addr %h wdata %h strobes %b want all 0", mem_addr, mem_wdata, {mem_cs, mem_we, mem_oe}); end
        n_chk++; if ({pc_out, ac_out, halted} !== {14'h100, 32'h0, 1'b0}) begin n_fail++; $display("FAIL rs_regs_reset: pc %h ac %h halted %b want 100/0/0", pc_out, ac_out, halted); end
        n_chk++; if (mem['h131] !== 32'h5A5A_0001) begin n_fail++; $display("FAIL rs_write_kept: got %h want 5A5A0001", mem['h131]); end
        rst = 1'b0;
        tick();
        n_chk++; if ({mem_addr, mem_cs, mem_oe} !== {14'h100, 2'b11}) begin n_fail++; $display("FAIL rs_refetch: addr %h cs %b oe %b want 100/1/1", mem_addr, mem_cs, mem_oe); end
        run_halt(200, n);
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rs_halted: got %b want 1", halted); end
        nexp = exp_q.size();
        for (int i = 0; i < nexp; i++) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_b + i >= wr_q.size()) begin n_fail++; $display("FAIL rs_wr%0d: missing, want %h", i, e); end
            else if (wr_q[wr_b + i] !== e) begin n_fail++; $display("FAIL rs_wr%0d: got %h want %h", i, wr_q[wr_b + i], e); end
        end
        n_chk++; if (wr_q.size() - wr_b !== nexp) begin n_fail++; $display("FAIL rs_wr_count: got %0d want %0d", wr_q.size() - wr_b, nexp); end
    endtask

    task automatic test_rst_mwait();
        int n;
        prep();
        poke('h100, ins(LDA, 'h130)); poke('h102, ins(HLT, 0));
        poke('h130, 32'h0000_0077);
        start();
        n = 0;
        while (!(mem_cs && mem_oe && mem_addr == 14'h130) && n < 50) begin tick(); n++; end
        n_chk++; if (n >= 50) begin n_fail++; $display("FAIL rm_wait_mrd: cycles %0d want <50", n); end
        tick();
        rst = 1'b1;
        tick();
        n_chk++; if ({mem_addr, mem_wdata, mem_cs, mem_we, mem_oe} !== '0) begin n_fail++; $display("FAIL rm_bus_reset: addr %h strobes %b want all 0", mem_addr, {mem_cs, mem_we, mem_oe}); end
        n_chk++; if ({pc_out, ac_out, halted} !== {14'h100, 32'h0, 1'b0}) begin n_fail++; $display("FAIL rm_regs_reset: pc %h ac %h halted %b want 100/0/0", pc_out, ac_out, halted); end
        rst = 1'b0;
        tick();
        n_chk++; if ({mem_addr, mem_cs, mem_oe} !== {14'h100, 2'b11}) begin n_fail++; $display("FAIL rm_refetch: addr %h cs %b oe %b want 100/1/1", mem_addr, mem_cs, mem_oe); end
        run_halt(200, n);
        n_chk++; if (ac_out !== 32'h77) begin n_fail++; $display("FAIL rm_ac: got %h want 77", ac_out); end
    endtask

    task automatic test_indirect();
        int n;
        logic [31:0] want_ac;
        int want_lat;
`ifdef ACC_CPU_INDIRECT_EN
        want_ac = 32'd7;     want_lat = 8;
`else
        want_ac = 32'h140;   want_lat = 6;
`endif
        prep();
        poke('h100, ins(LDA, 'h130) | 32'h8000_0000); poke('h102, ins(STA, 'h131)); poke('h104, ins(HLT, 0));
        poke('h130, 32'h140); poke('h140, 32'd7);
        start();
        exp_q.push_back({14'h131, want_ac});
        run_halt(200, n);
        n_chk++; if (ac_out !== want_ac) begin n_fail++; $display("FAIL ind_ac: got %h want %h", ac_out, want_ac); end
        n_chk++; if (fcyc('h102) - fcyc('h100) !== want_lat) begin n_fail++; $display("FAIL ind_lat: got %0d want %0d", fcyc('h102) - fcyc('h100), want_lat); end
        nexp = exp_q.size();
        for (int i = 0; i < nexp; i++) begin
            logic [45:0] e;
            e = exp_q.pop_front();
            n_chk++;
            if (wr_b + i >= wr_q.size()) begin n_fail++; $display("FAIL ind_wr%0d: missing, want %h", i, e); end
            else if (wr_q[wr_b + i] !== e) begin n_fail++; $display("FAIL ind_wr%0d: got %h want %h", i, wr_q[wr_b + i], e); end
        end
    endtask

    task automatic test_strobes();
        n_chk++; if (we_oe_bad !== 0) begin n_fail++; $display("FAIL we_oe_overlap: got %0d cycles want 0", we_oe_bad); end
        n_chk++; if (hlt_cs_bad !== 0) begin n_fail++; $display("FAIL cs_in_halt: got %0d cycles want 0", hlt_cs_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fib();
        test_skip();
        test_alu();
        test_rst_store();
        test_rst_mwait();
        test_indirect();
        test_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Synthesizable multi-cycle accumulator CPU core replacing the behavioural fetch/decode/execute loop driven from the CPU testbench. Parametrised in data/address width, reset vector and PC increment. It drives a single-port synchronous RAM (1-cycle read latency) and executes an 11-instruction accumulator ISA. A true halt state replaces the PC-rewind spin.

## Interface
- DATA_WIDTH, 32: data word, AC, IR, MBR width (>= 32)
- ADDR_WIDTH, 14: memory address and PC width
- RESET_PC, 'h100: PC value after reset
- PC_STEP, 2: PC increment per fetched instruction
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous, active-high
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read is presented
- mem_cs / mem_we / mem_oe  out  1 each  RAM chip select, write enable, output enable
- halted  out  1  high while in HALT
- pc_out  out  ADDR_WIDTH  current PC
- ac_out  out  DATA_WIDTH  current AC

## Operation
- Instruction: opcode IR[30:27], operand IR[26:0] truncated to ADDR_WIDTH (zero-extended if wider); IR[11:10] is the skip condition.
- Opcodes: 0 ADD, 1 HALT, 2 LOAD, 3 STORE, 4 CLEAR, 5 SKIP, 6 JUMP, 7 SUB, 8 AND, 9 OR, A NOT. B-F execute as NOP.
- ADD/SUB/AND/OR: AC <= AC op M[operand], modulo 2^DATA_WIDTH, no flags. LOAD: AC <= M[operand]. STORE: M[operand] <= AC. CLEAR: AC <= 0. NOT: AC <= ~AC. JUMP: PC <= operand.
- SKIP (AC signed): 00 AC<0, 01 AC==0, 10 AC>0; when true, PC <= PC+PC_STEP. 11 is reserved and never skips.
- FSM states: FETCH, FWAIT, DECODE, MRD, MWAIT, EXEC, STORE, HALT.
  - FETCH: mem_addr=PC, cs=oe=1.
  - FWAIT: IR <= mem_rdata; PC <= PC+PC_STEP.
  - DECODE: CLEAR/NOT/SKIP/JUMP/NOP complete here and go to FETCH. Memory-reading ops go to MRD. STORE goes to STORE. HALT goes to HALT.
  - MRD: mem_addr=operand, cs=oe=1.
  - MWAIT: MBR <= mem_rdata.
  - EXEC: AC update, then FETCH.
  - STORE: mem_addr=operand, mem_wdata=AC, cs=we=1, oe=0, then FETCH.
  - HALT: absorbing; all RAM strobes low; left only by rst.
- PC wraps modulo 2^ADDR_WIDTH. A JUMP to an odd address is honoured as-is.
- A skip is applied after the fetch increment (skips exactly one instruction).

## Timing
- Reset values: state FETCH, pc_out=RESET_PC, ac_out=0, IR=MBR=0, mem_addr=0, mem_wdata=0, cs=we=oe=0, halted=0. First fetch address is presented the cycle after rst deasserts.
- Latency (cycles FETCH to next FETCH): CLEAR/NOT/SKIP/JUMP/NOP 3; STORE 4; ADD/SUB/AND/OR/LOAD 6.
- RAM strobes are combinational from state. we and oe are never both high. cs is low in DECODE, EXEC and HALT.
- rst asserted in any state, including mid-STORE: next cycle is the reset state. The write in that cycle still occurs (sync RAM samples it); no further access follows.
- halted rises the cycle after DECODE of HALT.

## Configuration
- ACC_CPU_INDIRECT_EN defined: IR[31]=1 on memory ops selects indirect addressing. Two extra states follow DECODE:
  - IRD: read M[operand].
  - IWAIT: effective address <= mem_rdata[ADDR_WIDTH-1:0].
  - Then normal MRD/STORE. Adds 2 cycles.
- Undefined: IR[31] is ignored and all addressing is direct.

## Structure
- acc_cpu_pkg holds:
  - opcode enum
  - state enum
  - skip-condition constants (SKIP_NEG, SKIP_ZERO, SKIP_POS)
  - opcode/operand field bit positions
- Sub-module acc_cpu_alu: combinational, DATA_WIDTH-parametrised; ops ADD, SUB, AND, OR, NOT, PASS.

## Test plan
- Reset with rst=1 for 2 cycles, then release -> mem_addr='h100, cs=oe=1 on the first post-reset cycle; ac_out=0.
- M[100]=LOAD 11E, M[102]=ADD 120, M[104]=STORE 11C, M[106]=HALT; M[11E]=3, M[120]=5 -> M[11C]=8; halted=1; pc_out='h108; ADD takes 6 cycles.
- Fibonacci program (LOAD/ADD/STORE loop with SUB counter 9, SKIP 01, JUMP 100) -> stored F sequence ends at 55; halts.
- AC='hFFFFFFFF then SKIP 00 -> PC advances by 4; SKIP 10 -> no skip; SKIP 11 -> never skips.
- rst pulsed during STORE and during MWAIT -> next cycle all outputs at reset values; refetch from 'h100.
- With ACC_CPU_INDIRECT_EN: LOAD with IR[31]=1, operand 130, M[130]=140, M[140]=7 -> AC=7 in 8 cycles. Without the macro -> AC=140.
